// File: rtl/usb_sync_fifo_if.sv
// usb_sync_fifo_if
//   Handshake/status bundle for usb_sync_fifo.
//   master : FIFO user (drives flush, wr_en, w_data, rd_en; observes the rest)
//   slave  : the FIFO itself
//   Signals: flush, wr_en, w_data, rd_en, r_data, r_valid, flag_full,
//            flag_empty, flag_afull, flag_aempty, level, overflow, underflow.
//   With USB_FIFO_STATS_EN defined, also carries wr_count, rd_count and
//   drop_count (32-bit wrapping counters).
interface usb_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  logic                    flush;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    flag_full;
  logic                    flag_empty;
  logic                    flag_afull;
  logic                    flag_aempty;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic                    underflow;
`ifdef USB_FIFO_STATS_EN
  logic [31:0]             wr_count;
  logic [31:0]             rd_count;
  logic [31:0]             drop_count;
`endif

  modport master (
    output flush, wr_en, w_data, rd_en,
    input  r_data, r_valid, flag_full, flag_empty, flag_afull, flag_aempty,
           level, overflow, underflow
`ifdef USB_FIFO_STATS_EN
    , input wr_count, rd_count, drop_count
`endif
  );

  modport slave (
    input  flush, wr_en, w_data, rd_en,
    output r_data, r_valid, flag_full, flag_empty, flag_afull, flag_aempty,
           level, overflow, underflow
`ifdef USB_FIFO_STATS_EN
    , output wr_count, rd_count, drop_count
`endif
  );
endinterface

// File: rtl/usb_sync_fifo.sv
// usb_sync_fifo
//   Parametrised single-clock FIFO for USB hub packet / endpoint buffering.
//   Occupancy level, almost-full/almost-empty flags, sticky overflow and
//   underflow, synchronous flush, and registered or FWFT read mode.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : usb_sync_fifo_if.slave (write/read handshake, data, flags, level)
// Optional feature
//   USB_FIFO_STATS_EN : adds wr_count / rd_count / drop_count on the bus
//   (accepted writes, accepted reads, rejected writes; cleared only by rst).
module usb_sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic            clk,
  input  logic            rst,
  usb_sync_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Thresholds outside 0..DEPTH are pulled back into range.
  function automatic int clamp_thresh(input int t);
    if (t < 0)     return 0;
    if (t > DEPTH) return DEPTH;
    return t;
  endfunction

  localparam int AF_C = clamp_thresh(AFULL_THRESH);
  localparam int AE_C = clamp_thresh(AEMPTY_THRESH);

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_C);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_C);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;
  logic wr_rej;
  logic rd_rej;

  // Flags come from the registered level only.
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  assign bus.flag_full   = full;
  assign bus.flag_empty  = empty;
  assign bus.flag_afull  = (level_q >= LVL_AF);
  assign bus.flag_aempty = (level_q <= LVL_AE);
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

  // Flush masks both requests for the cycle it is asserted.
  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    wr_rej = 1'b0;
    rd_rej = 1'b0;
    if (!bus.flush) begin
      wr_acc = bus.wr_en && !full;
      rd_acc = bus.rd_en && !empty;
      wr_rej = bus.wr_en && full;
      rd_rej = bus.rd_en && empty;
    end
  end

  // Pointer / level / error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (wr_rej) overflow_q  <= 1'b1;
      if (rd_rej) underflow_q <= 1'b1;
    end
  end

  // Storage (not reset)
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.w_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally whenever the FIFO holds data.
      assign bus.r_data  = mem[rd_ptr];
      assign bus.r_valid = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_p1;
      logic                  vld_p1;

      // Read stage p1: one-cycle registered read, valid pulses once per pop
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_p1 <= '0;
          vld_p1   <= 1'b0;
        end else if (bus.flush) begin
          vld_p1   <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) rdata_p1 <= mem[rd_ptr];
        end
      end

      assign bus.r_data  = rdata_p1;
      assign bus.r_valid = vld_p1;
    end
  endgenerate

`ifdef USB_FIFO_STATS_EN
  logic [31:0] wr_cnt_q;
  logic [31:0] rd_cnt_q;
  logic [31:0] drop_cnt_q;

  // Statistics survive flush; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_acc) wr_cnt_q   <= wr_cnt_q + 32'd1;
      if (rd_acc) rd_cnt_q   <= rd_cnt_q + 32'd1;
      if (wr_rej) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign bus.wr_count   = wr_cnt_q;
  assign bus.rd_count   = rd_cnt_q;
  assign bus.drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_usb_sync_fifo.sv
// tb_usb_sync_fifo
//   Drives a registered-read FIFO and an FWFT FIFO with identical stimulus.
//   A queue-based reference model predicts occupancy, flags and errors; read
//   data expected from the registered-read FIFO is queued and consumed by an
//   independent monitor whenever r_valid is seen.
module tb_usb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if0 ();
  usb_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if1 ();

  usb_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  usb_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];     // model contents, head at index 0
  logic [DW-1:0] exp_q[$];  // expected registered-read words
  bit            m_ovf;
  bit            m_unf;
  int unsigned   m_wr, m_rd, m_drop;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input longint act, input longint exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic set_inputs(input bit wr, input bit rd, input logic [DW-1:0] d,
                            input bit fl);
    if0.wr_en = wr; if0.rd_en = rd; if0.w_data = d; if0.flush = fl;
    if1.wr_en = wr; if1.rd_en = rd; if1.w_data = d; if1.flush = fl;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf = 0; m_unf = 0;
    m_wr = 0; m_rd = 0; m_drop = 0;
  endtask

  task automatic check_state();
    int lvl;
    lvl = mq.size();
    chk("level",      if0.level,       lvl);
    chk("flag_full",  if0.flag_full,   lvl == DEPTH);
    chk("flag_empty", if0.flag_empty,  lvl == 0);
    chk("flag_afull", if0.flag_afull,  lvl >= AF);
    chk("flag_aempty",if0.flag_aempty, lvl <= AE);
    chk("overflow",   if0.overflow,    m_ovf);
    chk("underflow",  if0.underflow,   m_unf);
    chk("fwft_level", if1.level,       lvl);
    chk("fwft_ovf",   if1.overflow,    m_ovf);
    chk("fwft_unf",   if1.underflow,   m_unf);
    chk("fwft_valid", if1.r_valid,     lvl != 0);
    if (lvl != 0) chk("fwft_data", if1.r_data, mq[0]);
`ifdef USB_FIFO_STATS_EN
    chk("wr_count",   if0.wr_count,   m_wr);
    chk("rd_count",   if0.rd_count,   m_rd);
    chk("drop_count", if0.drop_count, m_drop);
    chk("fwft_wr_count", if1.wr_count, m_wr);
    chk("fwft_rd_count", if1.rd_count, m_rd);
`endif
  endtask

  // One clock of stimulus; the model is advanced from its pre-edge state.
  task automatic drive(input bit wr, input bit rd, input logic [DW-1:0] d,
                       input bit fl);
    bit is_full, is_empty;
    @(negedge clk);
    #1;
    set_inputs(wr, rd, d, fl);
    if (fl) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      is_full  = (mq.size() == DEPTH);
      is_empty = (mq.size() == 0);
      if (wr && is_full)  begin m_ovf = 1; m_drop++; end
      if (rd && is_empty) m_unf = 1;
      if (rd && !is_empty) begin exp_q.push_back(mq.pop_front()); m_rd++; end
      if (wr && !is_full)  begin mq.push_back(d); m_wr++; end
    end
    @(posedge clk);
    #1;
    check_state();
    set_inputs(0, 0, '0, 0);
  endtask

  // Registered-read monitor: every accepted read must surface exactly once,
  // on the cycle after its edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (if0.r_valid) begin
        if (exp_q.size() == 0) fail_now("r_valid_spurious", 1, 0);
        else chk("r_data", if0.r_data, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        fail_now("r_valid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int wprob;
    logic [DW-1:0] d;
    rst = 1'b1;
    set_inputs(0, 0, '0, 0);
    model_reset();
    #12;
    chk("rst_level",   if0.level,       0);
    chk("rst_empty",   if0.flag_empty,  1);
    chk("rst_aempty",  if0.flag_aempty, 1);
    chk("rst_full",    if0.flag_full,   0);
    chk("rst_afull",   if0.flag_afull,  0);
    chk("rst_r_valid", if0.r_valid,     0);
    chk("rst_r_data",  if0.r_data,      0);
    chk("rst_ovf",     if0.overflow,    0);
    chk("rst_unf",     if0.underflow,   0);
    chk("rst_fwft_valid", if1.r_valid,  0);
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x00..0x0F, one overflow attempt, drain, one underflow attempt
    for (int i = 0; i < DEPTH; i++) drive(1, 0, DW'(i), 0);
    drive(1, 0, 8'hEE, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 1, '0, 0);
    drive(0, 1, '0, 0);
    drive(0, 0, '0, 1);

    // Wrap: three rounds of write 10 / read 10
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) drive(1, 0, DW'($urandom), 0);
      for (int i = 0; i < 10; i++) drive(0, 1, '0, 0);
    end

    // Simultaneous read/write at full, empty and mid-occupancy
    for (int i = 0; i < DEPTH; i++) drive(1, 0, DW'($urandom), 0);
    drive(1, 1, 8'h5A, 0);
    drive(0, 0, '0, 1);
    drive(1, 1, 8'hC3, 0);
    drive(0, 0, '0, 1);
    for (int i = 0; i < 5; i++) drive(1, 0, DW'($urandom), 0);
    drive(1, 1, 8'h77, 0);
    drive(0, 0, '0, 1);

    // Flush at level 7 with a concurrent write (after forcing overflow)
    for (int i = 0; i < DEPTH; i++) drive(1, 0, DW'($urandom), 0);
    drive(1, 0, 8'h11, 0);
    for (int i = 0; i < DEPTH - 7; i++) drive(0, 1, '0, 0);
    drive(1, 0, 8'h99, 1);

    // FWFT single word: write into empty, then pop
    drive(1, 0, 8'hA5, 0);
    drive(0, 1, '0, 0);

    // Asynchronous reset mid-write at level 5, no clock edge in between
    for (int i = 0; i < 5; i++) drive(1, 0, DW'($urandom), 0);
    set_inputs(1, 0, 8'h42, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_level",   if0.level,      0);
    chk("arst_empty",   if0.flag_empty, 1);
    chk("arst_r_valid", if0.r_valid,    0);
    chk("arst_fwft_valid", if1.r_valid, 0);
    chk("arst_fwft_level", if1.level,   0);
    model_reset();
    #1 rst = 1'b0;
    set_inputs(0, 0, '0, 0);

    // Randomised traffic with shifting write bias and occasional flush
    for (int i = 0; i < 500; i++) begin
      wprob = (i / 100) % 3 == 0 ? 70 : ((i / 100) % 3 == 1 ? 30 : 50);
      d = DW'($urandom);
      drive($urandom_range(0, 99) < wprob, $urandom_range(0, 99) < 50, d,
            $urandom_range(0, 59) == 0);
    end

    drive(0, 0, '0, 0);
    drive(0, 0, '0, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
